jk_count_seq: RTL and testbench

//  Sequencer for a bank of N pre/clr-capable JK flip-flops wired as a counter.

---
 rtl/jk_count_seq_if.sv | 29 ++
 rtl/jk_count_seq.sv | 154 +++++++++++++++
 tb/tb_jk_count_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/jk_count_seq_if.sv
// Host handshake plus drive/readback wiring between jk_count_seq and its JK flop bank.
// master = host + flop bank side, slave = the sequencer.
interface jk_count_seq_if #(
   parameter int N = 4
);
   logic         start;
   logic         abort;
   logic         up;
   logic [N-1:0] load_val;
   logic [N-1:0] target;
   logic [N-1:0] q_fb;
   logic [N-1:0] j;
   logic [N-1:0] k;
   logic [N-1:0] pre_n;
   logic [N-1:0] clr_n;
   logic         busy;
   logic         done;
   logic         err;

   modport master (
      output start, abort, up, load_val, target, q_fb,
      input  j, k, pre_n, clr_n, busy, done, err
   );

   modport slave (
      input  start, abort, up, load_val, target, q_fb,
      output j, k, pre_n, clr_n, busy, done, err
   );
endinterface

// File: rtl/jk_count_seq.sv
// Sequencer for a bank of N JK flops used as a loadable up/down counter: presets the
// bank to a start value, then toggles it one step per clock until it reads the target.
module jk_count_seq #(
   parameter int N        = 4,
   parameter int LOAD_CYC = 2
) (
   input logic            clk,
   input logic            clr,
   jk_count_seq_if.slave  bus
);
   localparam int           LW       = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
   localparam logic [N:0]   STEP_LIM = {1'b1, {N{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SETTLE,
      COUNT
   } state_t;

   state_t          state_reg, state_next;
   logic            up_reg, up_next;
   logic [N-1:0]    load_reg, load_next;
   logic [N-1:0]    target_reg, target_next;
   logic            err_reg, err_next;
   logic [LW-1:0]   load_cnt_reg, load_cnt_next;
   logic [N:0]      step_reg, step_next;

   logic [N-1:0]    t;
   logic [N-1:0]    j_c, k_c, pre_n_c, clr_n_c;
   logic            busy_c, done_c;
   logic            match;

   // Synchronous-counter toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down).
   assign t[0] = 1'b1;
   generate
      for (genvar gi = 1; gi < N; gi++) begin : g_toggle
         assign t[gi] = up_reg ? (&bus.q_fb[gi-1:0]) : (&(~bus.q_fb[gi-1:0]));
      end
   endgenerate

   assign match = (bus.q_fb == target_reg);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_reg    <= IDLE;
         up_reg       <= 1'b0;
         load_reg     <= '0;
         target_reg   <= '0;
         err_reg      <= 1'b0;
         load_cnt_reg <= '0;
         step_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         up_reg       <= up_next;
         load_reg     <= load_next;
         target_reg   <= target_next;
         err_reg      <= err_next;
         load_cnt_reg <= load_cnt_next;
         step_reg     <= step_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      up_next       = up_reg;
      load_next     = load_reg;
      target_next   = target_reg;
      err_next      = err_reg;
      load_cnt_next = load_cnt_reg;
      step_next     = step_reg;
      j_c           = '0;
      k_c           = '0;
      pre_n_c       = '1;
      clr_n_c       = '1;
      busy_c        = 1'b0;
      done_c        = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (bus.start) begin
               up_next       = bus.up;
               load_next     = bus.load_val;
               target_next   = bus.target;
               err_next      = 1'b0;
               load_cnt_next = '0;
               state_next    = LOAD;
            end
         end

         LOAD: begin
            busy_c = 1'b1;
            if (bus.abort) begin
               state_next = IDLE;
            end else begin
               // Exactly one of pre_n/clr_n is low per bit, so a flop never sees both.
               pre_n_c = ~load_reg;
               clr_n_c = load_reg;
               if (load_cnt_reg == LW'(LOAD_CYC - 1)) begin
                  state_next = SETTLE;
               end else begin
                  load_cnt_next = load_cnt_reg + LW'(1);
               end
            end
         end

         SETTLE: begin
            busy_c = 1'b1;
            if (bus.abort) begin
               state_next = IDLE;
            end else if (bus.q_fb != load_reg) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (match) begin
               done_c     = 1'b1;
               state_next = IDLE;
            end else begin
               step_next  = '0;
               state_next = COUNT;
            end
         end

         COUNT: begin
            busy_c = 1'b1;
            if (bus.abort) begin
               state_next = IDLE;
            end else if ((step_reg == STEP_LIM) && !match) begin
               // A full lap of the counter without reaching target: the bank is not following.
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (match) begin
               done_c     = 1'b1;
               state_next = IDLE;
            end else begin
               j_c        = t;
               k_c        = t;
               step_next  = step_reg + (N + 1)'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.j     = j_c;
   assign bus.k     = k_c;
   assign bus.pre_n = pre_n_c;
   assign bus.clr_n = clr_n_c;
   assign bus.busy  = busy_c;
   assign bus.done  = done_c;
   assign bus.err   = err_reg;
endmodule

// File: tb/tb_jk_count_seq.sv
// Bench for jk_count_seq: a behavioural JK flop bank closes the loop, and each run is
// compared against an arithmetic model of load / count / match / guard outcomes.
module tb_jk_count_seq;
   localparam int N  = 4;
   localparam int LC = 2;

   logic clk = 1'b0;
   logic clr = 1'b0;

   jk_count_seq_if #(.N(N)) bus ();

   jk_count_seq #(.N(N), .LOAD_CYC(LC)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Flop bank: JK flops with preset/clear; stuck0 forces chosen bits to read 0.
   logic [N-1:0] bank_q = '0;
   logic [N-1:0] stuck0 = '0;
   always @(posedge clk) begin
      logic [N-1:0] nq;
      for (int i = 0; i < N; i++) begin
         if (!bus.pre_n[i])      nq[i] = 1'b1;
         else if (!bus.clr_n[i]) nq[i] = 1'b0;
         else case ({bus.j[i], bus.k[i]})
            2'b10:   nq[i] = 1'b1;
            2'b01:   nq[i] = 1'b0;
            2'b11:   nq[i] = ~bank_q[i];
            default: nq[i] = bank_q[i];
         endcase
      end
      bank_q <= nq & ~stuck0;
   end
   assign bus.q_fb = bank_q;

   int tests_run    = 0;
   int tests_failed = 0;

   int obs_len, obs_done_cnt, obs_done_at, obs_jk;
   int bad_pins, bad_both, bad_errbusy, bad_jkneq;
   bit timed_out;
   logic obs_err;
   logic [N-1:0] obs_q;

   int ex_len, ex_jk;
   bit ex_done, ex_err;
   logic [N-1:0] ex_q;

   // Reference: arithmetic outcome of one run given direction, start, target and stuck bits.
   task automatic model_run(input bit u, input logic [N-1:0] ld, input logic [N-1:0] tg,
                            input logic [N-1:0] msk);
      logic [N-1:0] qm;
      qm = ld & ~msk;
      ex_done = 0; ex_err = 0; ex_jk = 0;
      if (qm != ld) begin
         ex_err = 1; ex_len = LC + 1; ex_q = qm; return;
      end
      if (qm == tg) begin
         ex_done = 1; ex_len = LC + 1; ex_q = qm; return;
      end
      for (int s = 0; s <= (1 << N); s++) begin
         if (qm == tg) begin
            ex_done = 1; ex_len = LC + 2 + s; ex_q = qm; return;
         end
         if (s == (1 << N)) begin
            ex_err = 1; ex_len = LC + 2 + s; ex_q = qm; return;
         end
         qm = (u ? qm + 1'b1 : qm - 1'b1) & ~msk;
         ex_jk++;
      end
   endtask

   // One transaction; other host inputs are scrambled while busy to show they are ignored.
   task automatic do_run(input bit u, input logic [N-1:0] ld, input logic [N-1:0] tg,
                         input int abort_at);
      obs_len = 0; obs_done_cnt = 0; obs_done_at = 0; obs_jk = 0;
      bad_pins = 0; bad_both = 0; bad_errbusy = 0; bad_jkneq = 0; timed_out = 0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.up = u; bus.load_val = ld; bus.target = tg; bus.abort = 1'b0;
      @(posedge clk); #1;
      for (int c = 1; c <= 101; c++) begin
         if (c == 101) begin
            timed_out = 1;
            break;
         end
         bus.abort    = (c == abort_at);
         bus.start    = 1'($urandom_range(0, 1));
         bus.up       = 1'($urandom_range(0, 1));
         bus.load_val = N'($urandom);
         bus.target   = N'($urandom);
         @(negedge clk);
         if (!bus.busy) break;
         obs_len++;
         if (bus.done) begin
            obs_done_cnt++;
            obs_done_at = c;
         end
         if (bus.done && bus.err) bad_both++;
         if (bus.err) bad_errbusy++;
         if (bus.j !== bus.k) bad_jkneq++;
         if (bus.j != '0) obs_jk++;
         if (c <= LC && c != abort_at) begin
            if (bus.pre_n !== ~ld || bus.clr_n !== ld) bad_pins++;
         end else if (bus.pre_n !== '1 || bus.clr_n !== '1) begin
            bad_pins++;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      obs_err = bus.err;
      obs_q   = bank_q;
      $display("[TB] run up=%0d load=%0d target=%0d abort_at=%0d: busy %0d cyc, done %0d at %0d, err %0d, q=%0d",
               u, ld, tg, abort_at, obs_len, obs_done_cnt, obs_done_at, obs_err, obs_q);
   endtask

   task automatic test_reset;
      bus.start = 0; bus.abort = 0; bus.up = 0; bus.load_val = '0; bus.target = '0;
      clr = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
      tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %0b want 0", bus.done); end
      tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %0b want 0", bus.err); end
      tests_run++; if ({bus.j, bus.k} !== '0) begin tests_failed++; $display("FAIL reset_jk: got %h/%h want 0/0", bus.j, bus.k); end
      tests_run++; if ({bus.pre_n, bus.clr_n} !== '1) begin tests_failed++; $display("FAIL reset_pins: got %h/%h want f/f", bus.pre_n, bus.clr_n); end
      clr = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_count_up;
      model_run(1'b1, 4'd3, 4'd7, '0);
      do_run(1'b1, 4'd3, 4'd7, 0);
      tests_run++; if (obs_len !== ex_len) begin tests_failed++; $display("FAIL up_len: got %0d want %0d", obs_len, ex_len); end
      tests_run++; if (obs_done_cnt !== 1 || obs_done_at !== ex_len) begin tests_failed++; $display("FAIL up_done: got %0d at %0d want 1 at %0d", obs_done_cnt, obs_done_at, ex_len); end
      tests_run++; if (bad_pins !== 0) begin tests_failed++; $display("FAIL up_load_pins: got %0d bad cycles want 0", bad_pins); end
      tests_run++; if (obs_jk !== ex_jk) begin tests_failed++; $display("FAIL up_steps: got %0d want %0d", obs_jk, ex_jk); end
      repeat (3) @(negedge clk);
      tests_run++; if (bank_q !== 4'd7) begin tests_failed++; $display("FAIL up_hold: got %0d want 7", bank_q); end
   endtask

   task automatic test_count_down;
      model_run(1'b0, 4'd1, 4'd14, '0);
      do_run(1'b0, 4'd1, 4'd14, 0);
      tests_run++; if (obs_len !== ex_len) begin tests_failed++; $display("FAIL down_len: got %0d want %0d", obs_len, ex_len); end
      tests_run++; if (obs_done_cnt !== 1 || obs_done_at !== ex_len) begin tests_failed++; $display("FAIL down_done: got %0d at %0d want 1 at %0d", obs_done_cnt, obs_done_at, ex_len); end
      tests_run++; if (obs_q !== 4'd14) begin tests_failed++; $display("FAIL down_q: got %0d want 14", obs_q); end
   endtask

   task automatic test_zero_step;
      model_run(1'b1, 4'd9, 4'd9, '0);
      do_run(1'b1, 4'd9, 4'd9, 0);
      tests_run++; if (obs_len !== ex_len || obs_done_at !== ex_len) begin tests_failed++; $display("FAIL zero_len: got %0d/%0d want %0d", obs_len, obs_done_at, ex_len); end
      tests_run++; if (obs_jk !== 0) begin tests_failed++; $display("FAIL zero_jk: got %0d active cycles want 0", obs_jk); end
      tests_run++; if (obs_q !== 4'd9) begin tests_failed++; $display("FAIL zero_q: got %0d want 9", obs_q); end
   endtask

   task automatic test_load_fault;
      stuck0 = 4'b0100;
      model_run(1'b1, 4'd4, 4'd8, stuck0);
      do_run(1'b1, 4'd4, 4'd8, 0);
      stuck0 = '0;
      tests_run++; if (obs_err !== 1'b1) begin tests_failed++; $display("FAIL loadfault_err: got %0b want 1", obs_err); end
      tests_run++; if (obs_done_cnt !== 0) begin tests_failed++; $display("FAIL loadfault_done: got %0d want 0", obs_done_cnt); end
      tests_run++; if (obs_len !== ex_len || obs_jk !== 0) begin tests_failed++; $display("FAIL loadfault_len_jk: got %0d/%0d want %0d/0", obs_len, obs_jk, ex_len); end
   endtask

   task automatic test_abort;
      do_run(1'b1, 4'd0, 4'd12, LC + 4);
      tests_run++; if (obs_len !== LC + 4) begin tests_failed++; $display("FAIL abort_len: got %0d want %0d", obs_len, LC + 4); end
      tests_run++; if (obs_done_cnt !== 0) begin tests_failed++; $display("FAIL abort_done: got %0d want 0", obs_done_cnt); end
      tests_run++; if (obs_q !== 4'd2) begin tests_failed++; $display("FAIL abort_q: got %0d want 2", obs_q); end
      tests_run++; if (obs_err !== 1'b0) begin tests_failed++; $display("FAIL abort_err: got %0b want 0", obs_err); end
      model_run(1'b1, 4'd2, 4'd5, '0);
      do_run(1'b1, 4'd2, 4'd5, 0);
      tests_run++; if (obs_done_at !== ex_len || obs_q !== 4'd5) begin tests_failed++; $display("FAIL abort_restart: got done@%0d q=%0d want done@%0d q=5", obs_done_at, obs_q, ex_len); end
   endtask

   task automatic test_async_reset;
      logic [N-1:0] q_at_rst;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.up = 1'b1; bus.load_val = 4'd0; bus.target = 4'd15;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #3 clr = 1'b0;
      #1;
      tests_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin tests_failed++; $display("FAIL arst_flags: got busy=%0b done=%0b err=%0b want 0/0/0", bus.busy, bus.done, bus.err); end
      tests_run++; if ({bus.j, bus.k} !== '0 || {bus.pre_n, bus.clr_n} !== '1) begin tests_failed++; $display("FAIL arst_drive: got j=%h k=%h pre_n=%h clr_n=%h want 0 0 f f", bus.j, bus.k, bus.pre_n, bus.clr_n); end
      q_at_rst = bank_q;
      repeat (2) @(negedge clk);
      tests_run++; if (bank_q !== q_at_rst) begin tests_failed++; $display("FAIL arst_hold: got %0d want %0d", bank_q, q_at_rst); end
      clr = 1'b1;
      model_run(1'b0, 4'd5, 4'd2, '0);
      do_run(1'b0, 4'd5, 4'd2, 0);
      tests_run++; if (obs_done_at !== ex_len || obs_q !== 4'd2) begin tests_failed++; $display("FAIL arst_rerun: got done@%0d q=%0d want done@%0d q=2", obs_done_at, obs_q, ex_len); end
   endtask

   task automatic test_random;
      bit u;
      logic [N-1:0] ld, tg;
      for (int r = 0; r < 24; r++) begin
         u  = 1'($urandom_range(0, 1));
         ld = N'($urandom);
         tg = N'($urandom);
         stuck0 = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
         model_run(u, ld, tg, stuck0);
         do_run(u, ld, tg, 0);
         stuck0 = '0;
         tests_run++; if (timed_out || obs_len !== ex_len) begin tests_failed++; $display("FAIL rand_len[%0d]: got %0d (timeout %0b) want %0d", r, obs_len, timed_out, ex_len); end
         tests_run++; if (obs_done_cnt !== int'(ex_done) || (ex_done && obs_done_at !== ex_len)) begin tests_failed++; $display("FAIL rand_done[%0d]: got %0d at %0d want %0d at %0d", r, obs_done_cnt, obs_done_at, ex_done, ex_len); end
         tests_run++; if (obs_err !== ex_err) begin tests_failed++; $display("FAIL rand_err[%0d]: got %0b want %0b", r, obs_err, ex_err); end
         tests_run++; if (obs_q !== ex_q || obs_jk !== ex_jk) begin tests_failed++; $display("FAIL rand_q_steps[%0d]: got q=%0d steps=%0d want q=%0d steps=%0d", r, obs_q, obs_jk, ex_q, ex_jk); end
         tests_run++; if (bad_pins + bad_both + bad_errbusy + bad_jkneq !== 0) begin tests_failed++; $display("FAIL rand_drive[%0d]: got pins=%0d both=%0d errbusy=%0d jkneq=%0d want all 0", r, bad_pins, bad_both, bad_errbusy, bad_jkneq); end
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_zero_step();
      test_load_fault();
      test_abort();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
